phase_accumulator: RTL and testbench
====================================

PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 SHALL have parameter ACC_DW, default 32: accumulator and frequency-word width.
REQ-002 SHALL have parameter PHASE_DW, default 16: output phase width (≤ ACC_DW), matching the downstream DDS phase input.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port s_axis_freq_tdata, input, ACC_DW: unsigned frequency tuning word.
REQ-006 SHALL have port s_axis_freq_tvalid, input, 1: tuning word valid.
REQ-007 SHALL have port s_axis_freq_tready, output, 1: tuning word accepted when high.
REQ-008 SHALL have port enable, input, 1: run accumulator.
REQ-009 SHALL have port sync_clear, input, 1: zero the accumulator.
REQ-010 SHALL have port phase_offset, input, PHASE_DW: static phase offset added to output.
REQ-011 SHALL have port sweep_start, input, 1: single-cycle pulse that starts a linear frequency sweep.
REQ-012 SHALL have port sweep_step, input, ACC_DW signed: per-sample frequency increment.
REQ-013 SHALL have port sweep_stop, input, ACC_DW: unsigned terminal frequency.
REQ-014 SHALL have port sweep_done, output, 1: single-cycle pulse at sweep end.
REQ-015 SHALL have port m_axis_phase_tdata, output, PHASE_DW: unsigned phase to DDS.
REQ-016 SHALL have port m_axis_phase_tvalid, output, 1: phase valid (no tready; downstream never stalls).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, SWEEP; IDLE→RUN when enable=1; RUN→IDLE when enable=0; RUN→SWEEP on sweep_start; SWEEP→RUN when clamped to sweep_stop.
REQ-018 SHALL, in SWEEP with enable=0, hold state, freq and acc.
REQ-019 SHALL drive s_axis_freq_tready=1 in IDLE and RUN, and 0 in SWEEP.
REQ-020 SHALL, on tvalid&&tready, load freq from tdata; the new word is used from the next cycle.
REQ-021 SHALL, when a freq load and sweep_start coincide in RUN, take the load and start the sweep from the loaded word.
REQ-022 SHALL, on each cycle with enable=1, compute acc <= acc + freq modulo 2^ACC_DW; with enable=0, hold acc.
REQ-023 SHALL give sync_clear priority over accumulation: acc <= 0 on that cycle, while a coincident freq load still takes effect.
REQ-024 SHALL register m_axis_phase_tdata = acc[ACC_DW-1 -: PHASE_DW] + phase_offset (mod 2^PHASE_DW), using acc before that cycle's update: latency 1, and the first sample after reset is phase_offset.
REQ-025 SHALL assert m_axis_phase_tvalid one cycle after each enable=1 cycle; otherwise tvalid=0 and tdata holds.
REQ-026 SHALL, in SWEEP on each enable cycle, compute freq+sweep_step in ACC_DW+1 bits and clamp to sweep_stop when step>0 and sum≥stop, step<0 and sum≤stop, step=0, or the sum leaves [0, 2^ACC_DW); on clamp, pulse sweep_done for one cycle and go to RUN.

Reset
REQ-027 SHALL, on reset, immediately set acc=0, freq=0, state=IDLE, m_axis_phase_tdata=0, m_axis_phase_tvalid=0, sweep_done=0 and s_axis_freq_tready=0; s_axis_freq_tready SHALL go to 1 on the first clock after deassertion.
REQ-028 SHALL, on reset mid-sweep, abandon the sweep without pulsing sweep_done.

Configuration
REQ-029 SHALL, when PHASE_DITHER_EN is defined, add the low ACC_DW-PHASE_DW bits of an LFSR to acc before truncation to PHASE_DW (latency unchanged; LFSR advances only on enable cycles).
REQ-030 SHALL, when PHASE_DITHER_EN is undefined, use plain truncation and instantiate no LFSR.

Structure
REQ-031 SHALL place the FSM state enum, the default ACC_DW and the LFSR polynomial constant (x^32+x^22+x^2+x+1) in shared package dds_pkg.
REQ-032 SHALL implement the dither source as sub-module phase_lfsr (32-bit Galois LFSR, seed 1 on reset).

Verification (ACC_DW=32, PHASE_DW=16, dither off unless stated)
REQ-033 SHALL verify: load freq 0x0001_0000, offset 0, enable=1 → tdata 0x0000, 0x0001, 0x0002… with tvalid continuously 1.
REQ-034 SHALL verify: freq 0x8000_0000, offset 0x4000 → tdata 0x4000, 0xC000, 0x4000… (wrap-around).
REQ-035 SHALL verify: freq 0x100, step 0x100, stop 0x400, sweep_start → freq 0x200, 0x300, 0x400; sweep_done pulses once, coincident with freq reaching 0x400; tready=0 throughout SWEEP; step 0x300 → clamp to 0x400 on the first step.
REQ-036 SHALL verify: sync_clear pulse during RUN → tdata equals phase_offset two cycles later, then accumulation resumes.
REQ-037 SHALL verify: reset asserted mid-sweep, between clock edges → all outputs 0 before the next edge, no sweep_done, IDLE after release.
REQ-038 SHALL verify: with PHASE_DITHER_EN defined and freq 0x0000_8000 → tdata mean over 4096 samples within ±1 LSB of ideal, and tdata not purely periodic.

Source files
------------

// File: rtl/dds_pkg.sv
// ============================================================================
// dds_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the phase accumulator and its dither source.
//   state_t          : phase accumulator FSM encoding (IDLE / RUN / SWEEP)
//   DEFAULT_ACC_DW   : default accumulator / tuning-word width
//   LFSR_W           : width of the dither LFSR
//   LFSR_POLY        : Galois tap mask for x^32 + x^22 + x^2 + x + 1
//   LFSR_SEED        : LFSR value loaded on reset (must be non-zero)
// ============================================================================
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } state_t;

  localparam int DEFAULT_ACC_DW = 32;

  localparam int LFSR_W = 32;

  // Right-shifting Galois form: bit 31 is the x^32 feedback term, bits 21, 1
  // and 0 carry the x^22, x^2 and x^1 taps.
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 32'h0000_0001;

endpackage : dds_pkg

// File: rtl/phase_lfsr.sv
// ============================================================================
// phase_lfsr
// ----------------------------------------------------------------------------
// 32-bit Galois LFSR used as the phase dither source. It steps once per cycle
// in which "advance" is high and restarts from LFSR_SEED on reset.
//
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high reset (loads LFSR_SEED)
//   advance : step the register this cycle
//   lfsr    : current LFSR contents
// ============================================================================
module phase_lfsr
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_next;

  // Shift right; when a one falls out of bit 0 fold the taps back in.
  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) begin
      lfsr_next = (lfsr >> 1) ^ LFSR_POLY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next;
    end
  end

endmodule : phase_lfsr

// File: rtl/phase_accumulator.sv
// ============================================================================
// phase_accumulator
// ----------------------------------------------------------------------------
// Numerically controlled oscillator phase generator for a DDS. A tuning word
// is accumulated modulo 2^ACC_DW; the top PHASE_DW bits plus a static offset
// are registered out as the phase. A linear frequency sweep can be launched
// from RUN: the tuning word is stepped once per enabled sample until it
// reaches (or would pass) the terminal frequency.
//
// Optional feature macro: PHASE_DITHER_EN
//   defined   : low ACC_DW-PHASE_DW bits of an LFSR are added to the
//               accumulator before truncation (same latency)
//   undefined : plain truncation, no LFSR in the design
//
// Parameters
//   ACC_DW   : accumulator and frequency-word width
//   PHASE_DW : output phase width (<= ACC_DW)
//
// Ports
//   clk                 : clock, rising edge
//   reset               : asynchronous, active-high reset
//   s_axis_freq_tdata   : unsigned tuning word
//   s_axis_freq_tvalid  : tuning word valid
//   s_axis_freq_tready  : tuning word accepted when high (low in SWEEP)
//   enable              : run the accumulator this cycle
//   sync_clear          : zero the accumulator (wins over accumulation)
//   phase_offset        : static phase offset added to the output
//   sweep_start         : one-cycle pulse, starts a sweep from RUN
//   sweep_step          : signed per-sample frequency increment
//   sweep_stop          : unsigned terminal frequency
//   sweep_done          : one-cycle pulse when the sweep clamps
//   m_axis_phase_tdata  : phase to DDS
//   m_axis_phase_tvalid : phase valid (downstream never stalls)
//
// Handshake: a tuning word transfers on a rising edge where tvalid and
// tready are both high; it is used for accumulation from the next cycle.
// The phase output has no tready; tvalid marks each sample produced by an
// enabled cycle, and tdata holds its last value while tvalid is low.
// ============================================================================
module phase_accumulator
  import dds_pkg::*;
#(
  parameter int ACC_DW   = DEFAULT_ACC_DW,
  parameter int PHASE_DW = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ACC_DW-1:0]        s_axis_freq_tdata,
  input  logic                     s_axis_freq_tvalid,
  output logic                     s_axis_freq_tready,
  input  logic                     enable,
  input  logic                     sync_clear,
  input  logic [PHASE_DW-1:0]      phase_offset,
  input  logic                     sweep_start,
  input  logic signed [ACC_DW-1:0] sweep_step,
  input  logic [ACC_DW-1:0]        sweep_stop,
  output logic                     sweep_done,
  output logic [PHASE_DW-1:0]      m_axis_phase_tdata,
  output logic                     m_axis_phase_tvalid
);

  // Sweep arithmetic width: two guard bits so that freq + step is exact for
  // any unsigned freq and signed step, and out-of-range sums are visible.
  localparam int SW = ACC_DW + 2;

  state_t            state;
  logic [ACC_DW-1:0] freq;
  logic [ACC_DW-1:0] acc;
  logic              load;

  assign load = s_axis_freq_tvalid && s_axis_freq_tready;

  // --------------------------------------------------------------------------
  // Sweep step and clamp decision
  // --------------------------------------------------------------------------
  logic signed [SW-1:0] sweep_sum;
  logic signed [SW-1:0] stop_ext;
  logic                 step_neg;
  logic                 step_zero;
  logic                 sum_out_of_range;
  logic                 clamp;

  always_comb begin
    sweep_sum = $signed({2'b00, freq})
              + $signed({{2{sweep_step[ACC_DW-1]}}, sweep_step});
    stop_ext  = $signed({2'b00, sweep_stop});
    step_neg  = sweep_step[ACC_DW-1];
    step_zero = (sweep_step == '0);
    // Negative sum shows in the sign bit; a sum >= 2^ACC_DW sets the bit
    // just above the accumulator width.
    sum_out_of_range = sweep_sum[SW-1] || sweep_sum[SW-2];

    clamp = 1'b0;
    if (step_zero || sum_out_of_range) begin
      clamp = 1'b1;
    end else if (!step_neg && (sweep_sum >= stop_ext)) begin
      clamp = 1'b1;
    end else if (step_neg && (sweep_sum <= stop_ext)) begin
      clamp = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Phase source: truncated accumulator, optionally dithered
  // --------------------------------------------------------------------------
  logic [PHASE_DW-1:0] phase_top;

`ifdef PHASE_DITHER_EN
  // Only the bits that truncation would discard are dithered.
  localparam logic [ACC_DW-1:0] DITHER_MASK =
    (ACC_DW'(1) << (ACC_DW - PHASE_DW)) - ACC_DW'(1);

  logic [LFSR_W-1:0] lfsr_q;
  logic [ACC_DW-1:0] dither;

  phase_lfsr u_phase_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (enable),
    .lfsr    (lfsr_q)
  );

  assign dither    = ACC_DW'(lfsr_q) & DITHER_MASK;
  assign phase_top = PHASE_DW'((acc + dither) >> (ACC_DW - PHASE_DW));
`else
  assign phase_top = acc[ACC_DW-1 -: PHASE_DW];
`endif

  // --------------------------------------------------------------------------
  // Datapath: tuning word, accumulator and registered phase output
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq                <= '0;
      acc                 <= '0;
      m_axis_phase_tdata  <= '0;
      m_axis_phase_tvalid <= 1'b0;
    end else begin
      // A load is only possible outside SWEEP (tready is low there), so the
      // two freq sources never compete.
      if (load) begin
        freq <= s_axis_freq_tdata;
      end else if ((state == SWEEP) && enable) begin
        freq <= clamp ? sweep_stop : sweep_sum[ACC_DW-1:0];
      end

      if (sync_clear) begin
        acc <= '0;
      end else if (enable) begin
        acc <= acc + freq;
      end

      // Output uses the accumulator value from before this cycle's update.
      m_axis_phase_tvalid <= enable;
      if (enable) begin
        m_axis_phase_tdata <= phase_top + phase_offset;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered tready and sweep_done
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      s_axis_freq_tready <= 1'b0;
      sweep_done         <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          s_axis_freq_tready <= 1'b1;
          if (enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          s_axis_freq_tready <= 1'b1;
          if (!enable) begin
            state <= IDLE;
          end else if (sweep_start) begin
            state              <= SWEEP;
            s_axis_freq_tready <= 1'b0;
          end
        end
        SWEEP: begin
          // With enable low everything holds, including the sweep.
          s_axis_freq_tready <= 1'b0;
          if (enable && clamp) begin
            state              <= RUN;
            s_axis_freq_tready <= 1'b1;
            sweep_done         <= 1'b1;
          end
        end
        default: begin
          state              <= IDLE;
          s_axis_freq_tready <= 1'b1;
        end
      endcase
    end
  end

endmodule : phase_accumulator

// File: tb/tb_phase_accumulator.sv
// ============================================================================
// tb_phase_accumulator
// ----------------------------------------------------------------------------
// Directed bench for phase_accumulator (ACC_DW=32, PHASE_DW=16). Inputs are
// driven 1 time unit after each rising edge; outputs are checked at the same
// point, well away from the active edge.
// ============================================================================
module tb_phase_accumulator;
  import dds_pkg::*;

  localparam int ACC_DW   = 32;
  localparam int PHASE_DW = 16;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic [ACC_DW-1:0]        s_axis_freq_tdata;
  logic                     s_axis_freq_tvalid;
  logic                     s_axis_freq_tready;
  logic                     enable;
  logic                     sync_clear;
  logic [PHASE_DW-1:0]      phase_offset;
  logic                     sweep_start;
  logic signed [ACC_DW-1:0] sweep_step;
  logic [ACC_DW-1:0]        sweep_stop;
  logic                     sweep_done;
  logic [PHASE_DW-1:0]      m_axis_phase_tdata;
  logic                     m_axis_phase_tvalid;

  phase_accumulator #(
    .ACC_DW   (ACC_DW),
    .PHASE_DW (PHASE_DW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .s_axis_freq_tdata   (s_axis_freq_tdata),
    .s_axis_freq_tvalid  (s_axis_freq_tvalid),
    .s_axis_freq_tready  (s_axis_freq_tready),
    .enable              (enable),
    .sync_clear          (sync_clear),
    .phase_offset        (phase_offset),
    .sweep_start         (sweep_start),
    .sweep_step          (sweep_step),
    .sweep_stop          (sweep_stop),
    .sweep_done          (sweep_done),
    .m_axis_phase_tdata  (m_axis_phase_tdata),
    .m_axis_phase_tvalid (m_axis_phase_tvalid)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [PHASE_DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs enabled cycles, comparing each phase sample against exp_q.
  task automatic drain_phase(input string tag);
    logic [PHASE_DW-1:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check({tag, "_tdata"}, 32'(m_axis_phase_tdata), 32'(e));
      check({tag, "_tvalid"}, 32'(m_axis_phase_tvalid), 32'd1);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int done_seen;
    logic [31:0] sweep_exp [3];

    reset              = 1'b0;
    s_axis_freq_tdata  = '0;
    s_axis_freq_tvalid = 1'b0;
    enable             = 1'b0;
    sync_clear         = 1'b0;
    phase_offset       = '0;
    sweep_start        = 1'b0;
    sweep_step         = '0;
    sweep_stop         = '0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_tdata",  32'(m_axis_phase_tdata),  32'd0);
    check("rst_tvalid", 32'(m_axis_phase_tvalid), 32'd0);
    check("rst_done",   32'(sweep_done),          32'd0);
    check("rst_tready", 32'(s_axis_freq_tready),  32'd0);
    tick();
    tick();
    check("rst_hold_tready", 32'(s_axis_freq_tready), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_tready", 32'(s_axis_freq_tready), 32'd1);
    check("post_rst_state",  32'(dut.state),          32'(IDLE));

`ifndef PHASE_DITHER_EN
    // Ramp: freq 0x0001_0000 advances the phase by one LSB per sample
    s_axis_freq_tdata  = 32'h0001_0000;
    s_axis_freq_tvalid = 1'b1;
    tick();
    check("ramp_load_freq", dut.freq, 32'h0001_0000);
    s_axis_freq_tvalid = 1'b0;
    enable             = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(PHASE_DW'(k));
    drain_phase("ramp");
    check("ramp_state", 32'(dut.state), 32'(RUN));
    enable = 1'b0;
    tick();
    check("ramp_off_tvalid", 32'(m_axis_phase_tvalid), 32'd0);
    check("ramp_off_hold",   32'(m_axis_phase_tdata),  32'h0005);
    check("ramp_off_state",  32'(dut.state),           32'(IDLE));

    // Wrap: half-cycle word, offset 0x4000; clear and load coincide
    sync_clear         = 1'b1;
    s_axis_freq_tdata  = 32'h8000_0000;
    s_axis_freq_tvalid = 1'b1;
    phase_offset       = 16'h4000;
    tick();
    check("wrap_load_freq", dut.freq, 32'h8000_0000);
    sync_clear         = 1'b0;
    s_axis_freq_tvalid = 1'b0;
    enable             = 1'b1;
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'hC000);
    exp_q.push_back(16'h4000);
    exp_q.push_back(16'hC000);
    drain_phase("wrap");

    // sync_clear during RUN
    enable             = 1'b0;
    sync_clear         = 1'b1;
    s_axis_freq_tdata  = 32'h0001_0000;
    s_axis_freq_tvalid = 1'b1;
    phase_offset       = 16'h0010;
    tick();
    sync_clear         = 1'b0;
    s_axis_freq_tvalid = 1'b0;
    enable             = 1'b1;
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0012);
    drain_phase("clr_pre");
    sync_clear = 1'b1;
    exp_q.push_back(16'h0013);
    drain_phase("clr_edge");
    sync_clear = 1'b0;
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0012);
    drain_phase("clr_post");

    // Sweep 0x100 -> 0x400 in steps of 0x100
    s_axis_freq_tdata  = 32'h0000_0100;
    s_axis_freq_tvalid = 1'b1;
    sweep_step         = 32'sh0000_0100;
    sweep_stop         = 32'h0000_0400;
    tick();
    s_axis_freq_tvalid = 1'b0;
    sweep_start        = 1'b1;
    tick();
    sweep_start = 1'b0;
    check("sw_enter_state",  32'(dut.state),          32'(SWEEP));
    check("sw_enter_tready", 32'(s_axis_freq_tready), 32'd0);
    check("sw_enter_freq",   dut.freq,                32'h0000_0100);
    sweep_exp[0] = 32'h200;
    sweep_exp[1] = 32'h300;
    sweep_exp[2] = 32'h400;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sw_freq",   dut.freq,                sweep_exp[i]);
      check("sw_done",   32'(sweep_done),         (i == 2) ? 32'd1 : 32'd0);
      check("sw_tready", 32'(s_axis_freq_tready), (i == 2) ? 32'd1 : 32'd0);
    end
    tick();
    check("sw_done_single", 32'(sweep_done), 32'd0);
    check("sw_exit_state",  32'(dut.state),  32'(RUN));

    // Large step clamps at once; enable low inside SWEEP holds everything
    s_axis_freq_tdata  = 32'h0000_0100;
    s_axis_freq_tvalid = 1'b1;
    sweep_step         = 32'sh0000_0300;
    tick();
    s_axis_freq_tvalid = 1'b0;
    sweep_start        = 1'b1;
    tick();
    sweep_start = 1'b0;
    enable      = 1'b0;
    tick();
    check("hold_freq",   dut.freq,                32'h0000_0100);
    check("hold_state",  32'(dut.state),          32'(SWEEP));
    check("hold_tready", 32'(s_axis_freq_tready), 32'd0);
    check("hold_done",   32'(sweep_done),         32'd0);
    enable = 1'b1;
    tick();
    check("big_step_freq", dut.freq,        32'h0000_0400);
    check("big_step_done", 32'(sweep_done), 32'd1);

    // Load coincident with sweep_start, downward sweep 0x400 -> 0x200
    s_axis_freq_tdata  = 32'h0000_0400;
    s_axis_freq_tvalid = 1'b1;
    sweep_start        = 1'b1;
    sweep_step         = -32'sd256;
    sweep_stop         = 32'h0000_0200;
    tick();
    s_axis_freq_tvalid = 1'b0;
    sweep_start        = 1'b0;
    check("dn_load_freq", dut.freq,       32'h0000_0400);
    check("dn_state",     32'(dut.state), 32'(SWEEP));
    tick();
    check("dn_freq1", dut.freq,        32'h0000_0300);
    check("dn_done1", 32'(sweep_done), 32'd0);
    tick();
    check("dn_freq2", dut.freq,        32'h0000_0200);
    check("dn_done2", 32'(sweep_done), 32'd1);

    // Reset between edges in the middle of a sweep
    phase_offset       = 16'h1234;
    s_axis_freq_tdata  = 32'h0000_0100;
    s_axis_freq_tvalid = 1'b1;
    sweep_start        = 1'b1;
    sweep_step         = 32'sh0000_0100;
    sweep_stop         = 32'h0000_0400;
    tick();
    s_axis_freq_tvalid = 1'b0;
    sweep_start        = 1'b0;
    tick();
    check("mid_pre_freq",   dut.freq,                 32'h0000_0200);
    check("mid_pre_tvalid", 32'(m_axis_phase_tvalid), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("mid_tdata",  32'(m_axis_phase_tdata),  32'd0);
    check("mid_tvalid", 32'(m_axis_phase_tvalid), 32'd0);
    check("mid_tready", 32'(s_axis_freq_tready),  32'd0);
    check("mid_done",   32'(sweep_done),          32'd0);
    check("mid_freq",   dut.freq,                 32'd0);
    enable    = 1'b0;
    done_seen = 0;
    tick();
    if (sweep_done) done_seen++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sweep_done) done_seen++;
    end
    check("mid_no_done",    32'(done_seen),           32'd0);
    check("mid_idle_state", 32'(dut.state),           32'(IDLE));
    check("mid_idle_tready", 32'(s_axis_freq_tready), 32'd1);
`else
    // Dither: freq 0x8000 gives an ideal phase of k/2 LSB at sample k
    begin
      longint sum;
      int     irregular;
      logic [PHASE_DW-1:0] samp [4096];
      s_axis_freq_tdata  = 32'h0000_8000;
      s_axis_freq_tvalid = 1'b1;
      tick();
      s_axis_freq_tvalid = 1'b0;
      enable             = 1'b1;
      sum = 0;
      for (int k = 0; k < 4096; k++) begin
        tick();
        samp[k] = m_axis_phase_tdata;
        sum += longint'(m_axis_phase_tdata);
      end
      check("dith_tvalid", 32'(m_axis_phase_tvalid), 32'd1);
      // Ideal sum = sum(k/2) = 4193280; +-1 LSB over 4096 samples = +-4096
      check("dith_mean",
            32'((sum >= 64'sd4189184) && (sum <= 64'sd4197376)), 32'd1);
      irregular = 0;
      for (int k = 2; k < 4096; k++) begin
        if (PHASE_DW'(samp[k] - samp[k-2]) != PHASE_DW'(1)) irregular++;
      end
      check("dith_aperiodic", 32'(irregular > 0), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_phase_accumulator
